sync_fifo_ctrl: RTL

// - Single-clock FIFO: storage array, wrap-bit read/write pointers, status flags.
// - Sits behind the free-running enable counters of the FIFO datapath.
// - Turns raw wr_en/rd_en requests into qualified pointer increments.
// - Exports full/empty/almost/level status to the producer and consumer stages.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_ctrl_ptr.sv | 31 +++
 rtl/sync_fifo_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
// - FIFO_AW : address width the pointer type is built from
// - DEPTH   : number of storage entries (2**FIFO_AW)
// - ptr_t   : wrap-bit pointer, FIFO_AW+1 bits
// - ptr_full: full test on a write/read pointer pair
package sync_fifo_pkg;

  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;

  typedef logic [FIFO_AW:0] ptr_t;

  // Full when the wrap bits differ but the addresses coincide.
  function automatic logic ptr_full(ptr_t wptr, ptr_t rptr);
    return (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
           (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_ptr.sv
// fifo_ptr: wrap-bit pointer with increment enable.
// Ports:
// - clk   : rising-edge clock
// - rst   : asynchronous reset, active-high (pointer to 0)
// - inc_i : advance pointer by one this cycle
// - ptr_o : current pointer; MSB is the wrap bit, low bits address memory
module fifo_ptr
  import sync_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output ptr_t ptr_o
);

  ptr_t ptr_d, ptr_q;

  // Natural modulo-2**(AW+1) wrap, no special case needed.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ptr_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, wrap-bit pointers and status.
// Status flags and level are decoded from the registered pointers, so they
// follow the causing edge by one cycle and return to reset values as soon as
// rst asserts. Read data, read valid and the error flags are registered.
// Configuration macro: SYNC_FIFO_STICKY_ERR_EN
// - defined  : overflow/underflow latch on a rejected request until rst
// - undefined: overflow/underflow are one-cycle pulses
// Ports:
// - clk, rst               : clock, asynchronous active-high reset
// - wr_en, wr_data         : write request and data
// - rd_en                  : read request
// - rd_data, rd_valid      : registered read data, valid one clk after accept
// - full, empty            : DEPTH / zero words stored
// - almost_full/_empty     : level >= AF_TH / level <= AE_TH
// - level                  : stored word count, 0..DEPTH
// - overflow, underflow    : write rejected (full) / read rejected (empty)
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = FIFO_AW,
  parameter int unsigned AF_TH = 12,
  parameter int unsigned AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] AfTh = (AW + 1)'(AF_TH);
  localparam logic [AW:0] AeTh = (AW + 1)'(AE_TH);

  ptr_t wptr, rptr;
  logic wr_ok, rd_ok;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] rd_data_d, rd_data_q;
  logic          rd_valid_d, rd_valid_q;
  logic          overflow_d, overflow_q;
  logic          underflow_d, underflow_q;

  // Status from registered pointers.
  always_comb begin
    empty        = (wptr == rptr);
    full         = ptr_full(wptr, rptr);
    level        = wptr - rptr;
    almost_full  = (level >= AfTh);
    almost_empty = (level <= AeTh);
  end

  // A full FIFO can still pop, an empty one can still push; no bypass either way.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  fifo_ptr u_wptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_ok),
    .ptr_o (wptr)
  );

  fifo_ptr u_rptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_ok),
    .ptr_o (rptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr[AW-1:0]] <= wr_data;
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    if (rd_ok) rd_data_d = mem_q[rptr[AW-1:0]];
`ifdef SYNC_FIFO_STICKY_ERR_EN
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
`else
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
